// File: rtl/serial_adder_pkg.sv
// Shared types and parameter limits for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned WIDTH_MIN = 32'd2;
  localparam int unsigned WIDTH_MAX = 32'd64;

  function automatic logic width_ok(input int unsigned w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Single full-adder cell; the only arithmetic element of the serial datapath.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder with start/busy/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  generate
    if (!width_ok(WIDTH)) begin : g_bad_width
      $error("serial_adder: WIDTH out of range");
    end
  endgenerate

  state_e             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   a_sh_r, b_sh_r;
  logic [WIDTH-2:0]   res_sh_r;
  logic               carry_r;
  logic               busy_r, done_r, cout_r;
  logic [WIDTH-1:0]   sum_r;
  logic               load_s, step_s, finish_s, last_s;
  logic               bit_sum_s, bit_carry_s;
  logic [WIDTH-1:0]   full_s;

  assign last_s = (cnt_r == LAST_CNT);
  // Completed result once the current bit lands on top of the bits already shifted in.
  assign full_s = {bit_sum_s, res_sh_r};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = start ? RUN : IDLE;
      RUN:     state_s = last_s ? IDLE : RUN;
      default: state_s = IDLE;
    endcase
  end

  // Control strobes decoded from the current state
  always_comb begin
    load_s   = 1'b0;
    step_s   = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      IDLE:    load_s = start;
      RUN: begin
        step_s   = 1'b1;
        finish_s = last_s;
      end
      default: load_s = 1'b0;
    endcase
  end

  fa_cell u_fa_cell (
    .a    (a_sh_r[0]),
    .b    (b_sh_r[0]),
    .cin  (carry_r),
    .s    (bit_sum_s),
    .cout (bit_carry_s)
  );

  // Operand/result shift registers, carry flop and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r   <= '0;
      b_sh_r   <= '0;
      res_sh_r <= '0;
      carry_r  <= 1'b0;
      cnt_r    <= '0;
    end else if (load_s) begin
      a_sh_r   <= a;
      b_sh_r   <= b;
      res_sh_r <= '0;
      carry_r  <= cin;
      cnt_r    <= '0;
    end else if (step_s) begin
      a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
      b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
      res_sh_r <= full_s[WIDTH-1:1];
      carry_r  <= bit_carry_s;
      cnt_r    <= cnt_r + CNT_W'(1);
    end
  end

  // Handshake flags and result registers; results move only on the finishing edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else begin
      done_r <= finish_s;
      if (load_s) begin
        busy_r <= 1'b1;
      end else if (finish_s) begin
        busy_r <= 1'b0;
      end
      if (finish_s) begin
        sum_r  <= full_s;
        cout_r <= bit_carry_s;
      end
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_r;

  // Signed overflow: carry into the MSB differs from carry out of it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (finish_s) begin
      ovf_r <= carry_r ^ bit_carry_s;
    end
  end

  assign ovf = ovf_r;
`endif

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;

endmodule
